// File: rtl/display_scan_capture.sv
// Rebuilds six BCD digits from a multiplexed 7-segment scan. Each anode code must hold for
// SETTLE_CYCLES before its value is sampled. A frame is published only after all six digits
// have been seen. frame_valid drops when no frame completes within TIMEOUT_CYCLES.
module display_scan_capture #(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] anode,
    input  logic [3:0] Output_Display,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] digit4,
    output logic [3:0] digit5,
    output logic [3:0] digit6,
    output logic       frame_done,
    output logic       frame_valid,
    output logic       scan_error,
    output logic       bcd_error
);

    localparam logic [7:0]  SettleMax  = 8'(SETTLE_CYCLES);
    localparam logic [7:0]  SettleHit  = 8'(SETTLE_CYCLES - 1);
    localparam logic [23:0] TimeoutMax = 24'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StCollect, StCommit} state_e;

    state_e         state_q;
    logic [7:0]     anode_q, anode_prev_q;
    logic [3:0]     disp_q;
    logic [7:0]     settle_q, settle_d;
    logic [23:0]    tmo_q, tmo_d;
    logic [5:0]     mask_q, mask_d, mask_set;
    logic [5:0][3:0] stage_q, stage_d;
    logic [5:0][3:0] digit_q;
    logic           frame_done_q, frame_valid_q, frame_valid_d;
    logic           scan_error_q, bcd_error_q;

    logic           is_digit, is_blank;
    logic [2:0]     digit_idx;
    logic           capture, cap_digit, cap_illegal, commit_now;

    // Decode the registered anode code into a digit slot, blank, or illegal.
    always_comb begin
        is_digit  = 1'b1;
        is_blank  = 1'b0;
        digit_idx = 3'd0;
        case (anode_q)
            8'b1110_1111: digit_idx = 3'd0;
            8'b1101_1111: digit_idx = 3'd1;
            8'b1011_1111: digit_idx = 3'd2;
            8'b0111_1111: digit_idx = 3'd3;
            8'b1111_1110: digit_idx = 3'd4;
            8'b1111_1101: digit_idx = 3'd5;
            8'b1111_1111: begin
                is_digit = 1'b0;
                is_blank = 1'b1;
            end
            default:      is_digit = 1'b0;
        endcase
    end

    // Settle counting, capture qualification, staging/mask and timeout next state.
    always_comb begin
        // Capture fires only on the cycle the counter steps onto its saturation value.
        capture     = (anode_q == anode_prev_q) && (settle_q == SettleHit);
        cap_digit   = capture && is_digit;
        cap_illegal = capture && !is_digit && !is_blank;

        if (anode_q != anode_prev_q) begin
            settle_d = 8'd0;
        end else if (settle_q == SettleMax) begin
            settle_d = settle_q;
        end else begin
            settle_d = settle_q + 8'd1;
        end

        stage_d  = stage_q;
        mask_set = 6'b0;
        for (int i = 0; i < 6; i++) begin
            if (cap_digit && (digit_idx == 3'(i))) begin
                stage_d[i]  = disp_q;
                mask_set[i] = 1'b1;
            end
        end

        commit_now = cap_digit && ((mask_q | mask_set) == 6'b11_1111);
        if (cap_illegal || commit_now) begin
            mask_d = 6'b0;
        end else begin
            mask_d = mask_q | mask_set;
        end

        if (commit_now) begin
            tmo_d = 24'd0;
        end else if (tmo_q == TimeoutMax) begin
            tmo_d = tmo_q;
        end else begin
            tmo_d = tmo_q + 24'd1;
        end

        // A completing capture wins over a simultaneous timeout.
        if (commit_now) begin
            frame_valid_d = 1'b1;
        end else if (tmo_d == TimeoutMax) begin
            frame_valid_d = 1'b0;
        end else begin
            frame_valid_d = frame_valid_q;
        end
    end

    // Input registers and settle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            anode_q      <= 8'hFF;
            anode_prev_q <= 8'hFF;
            disp_q       <= 4'd0;
            settle_q     <= 8'd0;
        end else begin
            anode_q      <= anode;
            anode_prev_q <= anode_q;
            disp_q       <= Output_Display;
            settle_q     <= settle_d;
        end
    end

    // Frame FSM with registered outputs; COMMIT is the cycle the new digits are presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            mask_q        <= 6'b0;
            stage_q       <= '0;
            digit_q       <= '0;
            tmo_q         <= 24'd0;
            frame_done_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            scan_error_q  <= 1'b0;
            bcd_error_q   <= 1'b0;
        end else begin
            mask_q        <= mask_d;
            stage_q       <= stage_d;
            tmo_q         <= tmo_d;
            frame_valid_q <= frame_valid_d;
            frame_done_q  <= commit_now;
            scan_error_q  <= cap_illegal;
            bcd_error_q   <= cap_digit && (disp_q > 4'd9);
            if (commit_now) begin
                digit_q <= stage_d;
            end
            if (commit_now) begin
                state_q <= StCommit;
            end else if (mask_d == 6'b0) begin
                state_q <= StIdle;
            end else begin
                state_q <= StCollect;
            end
        end
    end

    assign digit1      = digit_q[0];
    assign digit2      = digit_q[1];
    assign digit3      = digit_q[2];
    assign digit4      = digit_q[3];
    assign digit5      = digit_q[4];
    assign digit6      = digit_q[5];
    assign frame_done  = frame_done_q;
    assign frame_valid = frame_valid_q;
    assign scan_error  = scan_error_q;
    assign bcd_error   = bcd_error_q;

endmodule

// File: doc/display_scan_capture.md
DISPLAY_SCAN_CAPTURE -- requirements
Module: display_scan_capture

Interface
REQ-001 SHALL provide parameter SETTLE_CYCLES, default 4: consecutive cycles an anode code must hold before its digit is sampled (legal range 1..255).
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 1000000: cycles without a completed frame before frame_valid drops (legal range 2..2^24-1).
REQ-003 SHALL provide port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL provide port anode, input, 8: active-low scanned anode bus from the display multiplexer.
REQ-006 SHALL provide port Output_Display, input, 4: BCD value driven for the currently enabled digit.
REQ-007 SHALL provide ports digit1..digit6, output, 4 each: reconstructed digit values of the last completed frame.
REQ-008 SHALL provide port frame_done, output, 1: one-cycle pulse when digit1..digit6 update.
REQ-009 SHALL provide port frame_valid, output, 1: high while completed frames arrive within TIMEOUT_CYCLES.
REQ-010 SHALL provide port scan_error, output, 1: one-cycle pulse on a settled illegal anode code.
REQ-011 SHALL provide port bcd_error, output, 1: one-cycle pulse when a sampled value exceeds 9.

Function
REQ-012 Anode decode SHALL be: 8'b11101111->digit1, 8'b11011111->digit2, 8'b10111111->digit3, 8'b01111111->digit4, 8'b11111110->digit5, 8'b11111101->digit6, 8'b11111111->blank, every other code->illegal.
REQ-013 Inputs anode and Output_Display SHALL be registered once before decode; all latencies below count from the registered copy.
REQ-014 A settle counter SHALL clear to 0 whenever registered anode differs from its previous-cycle value, otherwise increment, saturating at SETTLE_CYCLES.
REQ-015 A capture SHALL occur exactly once per dwell, on the cycle the settle counter reaches SETTLE_CYCLES; no capture on any later cycle of the same dwell.
REQ-016 A capture of a legal digit code SHALL write the registered Output_Display into that digit's staging register and set its bit in a 6-bit seen mask.
REQ-017 Recapture of an already-seen digit before the mask completes SHALL overwrite its staging value; the mask bit stays set.
REQ-018 A capture on the blank code SHALL have no effect on staging, mask or outputs.
REQ-019 A capture on an illegal code SHALL pulse scan_error the following cycle and clear the seen mask (frame aborted); staging contents are don't-care.
REQ-020 A captured value 10..15 SHALL still be staged and SHALL pulse bcd_error the following cycle.
REQ-021 When the seen mask becomes 6'b111111, the next cycle SHALL copy all six staging registers to digit1..digit6 simultaneously, pulse frame_done, set frame_valid, clear the mask and clear the timeout counter.
REQ-022 digit1..digit6 SHALL change only on frame_done cycles (atomic update, never a partial frame).
REQ-023 A timeout counter SHALL increment every cycle except frame_done cycles, saturating at TIMEOUT_CYCLES; on reaching TIMEOUT_CYCLES frame_valid SHALL go 0; digit outputs hold.
REQ-024 A capture completing the mask on the same cycle the timeout is reached SHALL take priority: frame_done pulses next cycle and frame_valid ends high.
REQ-025 State machine SHALL have states IDLE (mask empty), COLLECT (mask partial), COMMIT (one cycle, outputs update); IDLE->COLLECT on first legal capture, COLLECT->COMMIT on full mask, COMMIT->IDLE unconditionally, COLLECT->IDLE on illegal capture.

Reset
REQ-026 While reset is high SHALL force digit1..digit6=0, frame_done=0, frame_valid=0, scan_error=0, bcd_error=0, mask=0, staging=0, both counters=0, state=IDLE, registered anode=8'hFF.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; no frame_done until a full new frame after release.

Verification (SETTLE_CYCLES=4, TIMEOUT_CYCLES=64)
REQ-028 Scan digits 1..6 with values 1,2,3,4,5,6, dwell 8 cycles each -> one frame_done after the digit6 capture; digit1..digit6=1..6, frame_valid=1.
REQ-029 Anode toggles every 3 cycles (below settle) -> no captures, no frame_done, frame_valid stays 0 and counters behave per REQ-023.
REQ-030 Mid-frame anode=8'b11001111 held 6 cycles -> single scan_error pulse, mask cleared; completing digits 4..6 only gives no frame_done.
REQ-031 Digit3 value 4'hB in a full frame -> one bcd_error pulse, frame_done, digit3=4'hB.
REQ-032 After one valid frame, hold anode=8'hFF 70 cycles -> frame_valid falls exactly 64 cycles after frame_done; digits retain previous values.
REQ-033 Reset pulsed after digits 1..3 captured, then full frame 9,8,7,6,5,4 -> outputs 0 until the single frame_done, then 9,8,7,6,5,4.
